instruction_fetch_phase: RTL and testbench
==========================================

Name: instruction_fetch_phase

Overview:
Fetch stage feeding the decode stage of the 5-stage MIPS datapath. It produces the IF/ID pipeline contents (instruction word, PC+4, valid) that decode consumes. It owns the program counter, drives the instruction-memory address, and applies redirects from decode (Jump/JumpRegister) and execute (taken branch). It implements stall and flush, and has no branch delay slots.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction word inserted into IF/ID on flush/reset (sll $0,$0,0)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
ImemAddr  out  32  byte address to instruction memory (= current PC)
ImemData  in  32  instruction word; combinational read, valid same cycle as ImemAddr
Stall  in  1  hazard unit: hold PC and IF/ID
BranchTaken  in  1  execute stage: branch resolved taken
BranchTarget  in  32  execute stage branch target
Jump  in  1  decode stage: j/jal
JumpTarget  in  32  decode stage {pc[31:28], instr_index<<2}
JumpRegister  in  1  decode stage: jr/jalr
JumpRegTarget  in  32  decode stage rs value
instr_out  out  32  IF/ID instruction word
pc_out  out  32  IF/ID PC+4 of instr_out
valid_out  out  1  IF/ID holds a real instruction
AddrError  out  1  one-cycle pulse: applied redirect target had nonzero bits [1:0]

Behaviour:
- Reset low (async): PC=RESET_PC, instr_out=NOP_INSTR, pc_out=0, valid_out=0, AddrError=0. First fetch is at RESET_PC in the first cycle after Reset deasserts.
- ImemAddr = PC (combinational). IF/ID latency: the word at ImemAddr in cycle n appears on instr_out after edge n+1.
- Next-PC priority per edge, highest first:
  1. BranchTaken: PC<=BranchTarget.
  2. JumpRegister: PC<=JumpRegTarget.
  3. Jump: PC<=JumpTarget.
  4. Stall: PC holds.
  5. Otherwise: PC<=PC+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- IF/ID update per edge:
  - BranchTaken: IF/ID flushed (instr_out=NOP_INSTR, pc_out=0, valid_out=0).
  - Jump or JumpRegister (no BranchTaken): IF/ID flushed; the word fetched this cycle is wrong-path.
  - Stall only: IF/ID holds all three fields.
  - Otherwise: instr_out<=ImemData, pc_out<=PC+4, valid_out<=1.
- Redirect overrides Stall. A redirect asserted during a stall is applied that edge, not deferred.
- Simultaneous BranchTaken and Jump/JumpRegister: BranchTaken wins, because the execute-stage instruction is older. Jump and JumpRegister both asserted: JumpRegister wins. This case is a decoder error, but its behaviour is fixed.
- Alignment: the applied target has bits [1:0] forced to 0. AddrError<=1 for exactly the next cycle when the applied target's raw bits [1:0] != 0. AddrError<=0 otherwise, including when a lower-priority misaligned target is ignored.
- No internal state beyond the PC, the IF/ID fields and AddrError.

Decomposition:
- Shared package: NOP_INSTR, RESET_PC default, redirect-select encoding (SEL_SEQ, SEL_HOLD, SEL_JUMP, SEL_JR, SEL_BRANCH, 3 bits).
- One sub-module: program_counter. It contains the priority next-PC mux, the PC register and alignment/AddrError. The IF/ID register stays in the top.

Test Plan:
- Reset deassert, ImemData=0x2008_0005 -> ImemAddr=0x0; after edge 1, instr_out=0x2008_0005, pc_out=0x4, valid_out=1, ImemAddr=0x4.
- Stall high 3 cycles at PC=0x8 -> ImemAddr stays 0x8; instr_out/pc_out/valid_out unchanged; on release, PC advances to 0xC.
- Jump=1, JumpTarget=0x0040_0020, with BranchTaken=1, BranchTarget=0x0000_0100, Stall=1 in the same cycle -> next ImemAddr=0x100, valid_out=0, instr_out=0x0.
- JumpRegister=1, JumpRegTarget=0x0040_0013 -> ImemAddr=0x0040_0010, AddrError high exactly one cycle, IF/ID flushed.
- PC at 0xFFFF_FFFC, no stall/redirect -> ImemAddr=0x0, pc_out=0x0 for that instruction.
- Reset low mid-stream (PC=0x40, valid_out=1), asserted between edges -> outputs go to reset values immediately without a clock edge; ImemAddr=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_phase_pkg.sv
// Shared definitions for the fetch stage: default constants and the
// next-PC select encoding used by both the PC block and the IF/ID register.
package instruction_fetch_phase_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_JUMP   = 3'd2,
    SEL_JR     = 3'd3,
    SEL_BRANCH = 3'd4
  } pc_sel_e;

  // Execute-stage branch is the oldest instruction, so it outranks decode redirects.
  function automatic pc_sel_e select_next_pc(
    input logic branch_taken,
    input logic jump_register,
    input logic jump,
    input logic stall
  );
    if (branch_taken)       return SEL_BRANCH;
    else if (jump_register) return SEL_JR;
    else if (jump)          return SEL_JUMP;
    else if (stall)         return SEL_HOLD;
    else                    return SEL_SEQ;
  endfunction

  function automatic logic is_redirect(input pc_sel_e sel);
    return (sel == SEL_BRANCH) || (sel == SEL_JR) || (sel == SEL_JUMP);
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter: priority next-PC selection, PC register, and the
// one-cycle misaligned-redirect flag.
module program_counter
  import instruction_fetch_phase_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jump_register,
  input  logic [31:0] jump_reg_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output pc_sel_e     sel,
  output logic        addr_error
);

  logic [31:0] raw_target;
  logic [31:0] next_pc;
  logic        next_addr_error;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    sel        = select_next_pc(branch_taken, jump_register, jump, stall);
    pc_plus4   = pc + 32'd4;
    raw_target = '0;
    next_pc    = pc_plus4;
    case (sel)
      SEL_BRANCH: raw_target = branch_target;
      SEL_JR:     raw_target = jump_reg_target;
      SEL_JUMP:   raw_target = jump_target;
      default:    raw_target = '0;
    endcase
    case (sel)
      SEL_HOLD: next_pc = pc;
      SEL_SEQ:  next_pc = pc_plus4;
      default:  next_pc = {raw_target[31:2], 2'b00};
    endcase
    // Only the target actually applied can raise the flag; ignored ones never do.
    next_addr_error = is_redirect(sel) && (raw_target[1:0] != 2'b00);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      pc         <= RESET_PC;
      addr_error <= 1'b0;
    end else begin
      pc         <= next_pc;
      addr_error <= next_addr_error;
    end
  end

endmodule

// File: rtl/instruction_fetch_phase.sv
// Fetch stage of the 5-stage MIPS pipeline: drives instruction memory from
// the PC and fills the IF/ID register, with stall, flush and redirects.
module instruction_fetch_phase
  import instruction_fetch_phase_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        JumpRegister,
  input  logic [31:0] JumpRegTarget,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        AddrError
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  pc_sel_e     sel;

  program_counter #(
    .RESET_PC (RESET_PC)
  ) u_program_counter (
    .Clk             (Clk),
    .Reset           (Reset),
    .stall           (Stall),
    .branch_taken    (BranchTaken),
    .branch_target   (BranchTarget),
    .jump            (Jump),
    .jump_target     (JumpTarget),
    .jump_register   (JumpRegister),
    .jump_reg_target (JumpRegTarget),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .sel             (sel),
    .addr_error      (AddrError)
  );

  assign ImemAddr = pc;

  // Any redirect squashes the word fetched this cycle; it is wrong-path.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      instr_out <= NOP_INSTR;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else begin
      case (sel)
        SEL_HOLD: begin
          instr_out <= instr_out;
          pc_out    <= pc_out;
          valid_out <= valid_out;
        end
        SEL_SEQ: begin
          instr_out <= ImemData;
          pc_out    <= pc_plus4;
          valid_out <= 1'b1;
        end
        default: begin
          instr_out <= NOP_INSTR;
          pc_out    <= '0;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_phase.sv
// Scoreboard bench for instruction_fetch_phase: a reference model pushes the
// expected post-edge state per driven cycle; it is popped and compared after the edge.
module tb_instruction_fetch_phase;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jump_register;
  logic [31:0] jump_reg_target;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        addr_error;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcout;
    logic        valid;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  logic        m_valid;

  instruction_fetch_phase dut (
    .Clk           (clk),
    .Reset         (rst_n),
    .ImemAddr      (imem_addr),
    .ImemData      (imem_data),
    .Stall         (stall),
    .BranchTaken   (branch_taken),
    .BranchTarget  (branch_target),
    .Jump          (jump),
    .JumpTarget    (jump_target),
    .JumpRegister  (jump_register),
    .JumpRegTarget (jump_reg_target),
    .instr_out     (instr_out),
    .pc_out        (pc_out),
    .valid_out     (valid_out),
    .AddrError     (addr_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return {~a[15:0], a[15:0] ^ 16'h5A5A};
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_instr = 32'h0;
    m_pcout = 32'h0;
    m_valid = 1'b0;
  endtask

  // One clock cycle: drive at negedge, predict, then compare after the rising edge.
  task automatic step(input logic st, input logic br, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt,
                      input logic jr, input logic [31:0] jrt);
    exp_t        e;
    logic [31:0] t;
    logic        redirect;
    @(negedge clk);
    stall = st; branch_taken = br; branch_target = bt;
    jump = j; jump_target = jt; jump_register = jr; jump_reg_target = jrt;
    check("imem_addr_pre", imem_addr, m_pc);
    redirect = br | jr | j;
    t = br ? bt : (jr ? jrt : jt);
    if (redirect) begin
      m_pc = {t[31:2], 2'b00}; m_instr = 32'h0; m_pcout = 32'h0; m_valid = 1'b0;
      e.err = (t[1:0] != 2'b00);
    end else if (st) begin
      e.err = 1'b0;
    end else begin
      m_instr = mem_word(m_pc); m_pcout = m_pc + 32'd4; m_valid = 1'b1;
      m_pc = m_pc + 32'd4;
      e.err = 1'b0;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcout = m_pcout; e.valid = m_valid;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("imem_addr", imem_addr, e.pc);
      check("instr_out", instr_out, e.instr);
      check("pc_out", pc_out, e.pcout);
      check("valid_out", {31'd0, valid_out}, {31'd0, e.valid});
      check("addr_error", {31'd0, addr_error}, {31'd0, e.err});
    end
  endtask

  task automatic seq();
    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b1; branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0; jump_register = 1'b0; jump_reg_target = '0;
    model_reset();
    #12;
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_addr_error", {31'd0, addr_error}, 32'd0);
    // Stall held across the first post-release edge keeps state at reset values.
    @(negedge clk);
    rst_n = 1'b1;

    seq();
    check("first_instr", instr_out, 32'h2008_0005);
    check("first_pc_out", pc_out, 32'h4);
    check("first_valid", {31'd0, valid_out}, 32'd1);
    check("first_addr", imem_addr, 32'h4);

    seq();
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("stall_addr", imem_addr, 32'h8);
    check("stall_pc_out", pc_out, 32'h8);
    seq();
    check("release_addr", imem_addr, 32'hC);

    step(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0040_0020, 1'b0, 32'h0);
    check("br_wins_addr", imem_addr, 32'h100);
    check("br_wins_valid", {31'd0, valid_out}, 32'd0);
    check("br_wins_instr", instr_out, 32'h0);

    step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0040_0013);
    check("jr_addr", imem_addr, 32'h0040_0010);
    check("jr_err", {31'd0, addr_error}, 32'd1);
    seq();
    check("jr_err_clear", {31'd0, addr_error}, 32'd0);

    step(1'b0, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0303, 1'b0, 32'h0);
    check("ignored_misalign_err", {31'd0, addr_error}, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0604);
    check("jr_over_j_addr", imem_addr, 32'h604);

    step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    seq();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_pc_out", pc_out, 32'h0);
    check("wrap_valid", {31'd0, valid_out}, 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] bt, jt, jrt;
      bt  = $urandom; jt = $urandom; jrt = $urandom;
      if ($urandom_range(0, 3) != 0) bt[1:0]  = 2'b00;
      if ($urandom_range(0, 3) != 0) jt[1:0]  = 2'b00;
      if ($urandom_range(0, 3) != 0) jrt[1:0] = 2'b00;
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, bt,
           $urandom_range(0, 9) == 0, jt, $urandom_range(0, 9) == 0, jrt);
    end

    step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_003C, 1'b0, 32'h0);
    seq();
    check("pre_reset_addr", imem_addr, 32'h40);
    check("pre_reset_valid", {31'd0, valid_out}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", imem_addr, 32'h0);
    check("async_rst_instr", instr_out, 32'h0);
    check("async_rst_pc_out", pc_out, 32'h0);
    check("async_rst_valid", {31'd0, valid_out}, 32'd0);
    check("async_rst_err", {31'd0, addr_error}, 32'd0);
    model_reset();
    stall = 1'b1; branch_taken = 1'b0; jump = 1'b0; jump_register = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seq();
    check("refetch_instr", instr_out, 32'h2008_0005);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
